// File: rtl/mem_resp_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mem_resp_pkg
// Shared definitions for the memory responder: FSM state type and the
// wait-counter width.
// Ports: none (package).
// ----------------------------------------------------------------------------
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_resp_ctrl_if.sv
// ----------------------------------------------------------------------------
// mem_resp_ctrl_if
// Request/response handshake bundle between the core (master) and the
// memory responder (slave).
// Signals:
//   req_valid/req_ready     request handshake
//   req_we/addr/wdata       request payload (store when req_we=1)
//   resp_valid/resp_ready   response handshake
//   resp_rdata/resp_err     response payload
// ----------------------------------------------------------------------------
interface mem_resp_ctrl_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_resp_ctrl_array.sv
// ----------------------------------------------------------------------------
// mem_resp_array
// DEPTH x 32 word storage, synchronous write and synchronous registered read
// sharing one word index. Contents are not reset.
// Ports:
//   i_clk    clock
//   i_we     write enable (writes i_wdata to word i_idx)
//   i_re     read enable  (registers word i_idx into o_rdata)
//   i_idx    word index
//   i_wdata  write data
//   o_rdata  registered read data
// ----------------------------------------------------------------------------
module mem_resp_array #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned IDX_W = 6
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic             i_re,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);
    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/mem_resp_ctrl.sv
// ----------------------------------------------------------------------------
// mem_resp_ctrl
// Memory-side responder: accepts one load/store request at a time, inserts
// RD_WAIT/WR_WAIT wait states, accesses the word array and returns a response.
// Ports:
//   clk      clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      request/response handshake (slave side)
// ----------------------------------------------------------------------------
module mem_resp_ctrl
    import mem_resp_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned RD_WAIT = 2,
    parameter int unsigned WR_WAIT = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    mem_resp_ctrl_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic              r_resp_err;

    logic              w_err;
    logic              w_arr_we;
    logic              w_arr_re;
    logic [IDX_W-1:0]  w_idx;
    logic [31:0]       w_arr_rdata;
    logic [CNT_W-1:0]  w_load_cnt;

    // DEPTH is a power of two, so "word index >= DEPTH" is any set bit above the index field
    assign w_idx      = r_addr[2 +: IDX_W];
    assign w_err      = (r_addr[1:0] != 2'b00) | (|r_addr[ADDR_W-1:2+IDX_W]);
    assign w_arr_we   = (r_state == ACCESS) &  r_we & ~w_err;
    assign w_arr_re   = (r_state == ACCESS) & ~r_we & ~w_err;
    assign w_load_cnt = bus.req_we ? CNT_W'(WR_WAIT) : CNT_W'(RD_WAIT);

    mem_resp_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .i_clk   (clk),
        .i_we    (w_arr_we),
        .i_re    (w_arr_re),
        .i_idx   (w_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_arr_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_we        <= bus.req_we;
                        r_addr      <= bus.req_addr;
                        r_wdata     <= bus.req_wdata;
                        r_cnt       <= w_load_cnt;
                        r_req_ready <= 1'b0;
                        r_state     <= (w_load_cnt != '0) ? WAIT : ACCESS;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_state <= RESP;
                end
                RESP: begin
                    // First RESP cycle waits for the array's registered read data,
                    // then the response registers are loaded and held until handshake.
                    if (!r_resp_valid) begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= w_err;
                        r_resp_rdata <= (r_we | w_err) ? '0 : w_arr_rdata;
                    end else if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;
endmodule
